// File: rtl/tdc_meas_ctrl.sv
// rtl/tdc_meas_ctrl.sv - TDC start/stop interval measurement controller
// Counts coarse clk1_out cycles between start and stop hits and merges in the fine codes.
module tdc_meas_ctrl #(
    parameter int COARSE_W     = 16,
    parameter int FINE_W       = 7,
    parameter int BINS_PER_CLK = 100,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int AUTO_REARM   = 0,
    parameter int RES_W        = COARSE_W + FINE_W
) (
    input  logic              clk1_out,
    input  logic              rst_and_lock,
    input  logic              arm,
    input  logic              abort,
    input  logic              start_vld,
    input  logic [FINE_W-1:0] start_fine,
    input  logic              stop_vld,
    input  logic [FINE_W-1:0] stop_fine,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_interval,
    output logic              res_timeout,
    output logic              res_err,
    output logic              busy,
    output logic [15:0]       meas_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_CALC,
        S_DONE
    } state_t;

    localparam logic [COARSE_W-1:0] TIMEOUT_VAL = COARSE_W'(TIMEOUT_CYC);
    localparam logic [FINE_W-1:0]   FINE_MAX    = FINE_W'(BINS_PER_CLK - 1);
    localparam logic [RES_W-1:0]    BINS_RES    = RES_W'(BINS_PER_CLK);

    state_t              state;
    state_t              state_nxt;
    logic                handshake;
    logic [COARSE_W-1:0] coarse;
    logic [COARSE_W-1:0] coarse_inc;
    logic [FINE_W-1:0]   start_lat;
    logic [FINE_W-1:0]   stop_lat;
    logic [FINE_W-1:0]   start_c;
    logic [FINE_W-1:0]   stop_c;
    logic                to_flag;
    logic [RES_W-1:0]    interval_sum;
    logic [RES_W-1:0]    interval_r;
    logic                timeout_r;
    logic                err_r;
    logic [15:0]         cnt_r;

    assign coarse_inc = coarse + COARSE_W'(1);

    always_comb begin
        state_nxt = state;
        handshake = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    if (start_vld) state_nxt = stop_vld ? S_CALC : S_RUN;
                end
                S_RUN: begin
                    if (stop_vld || coarse_inc == TIMEOUT_VAL) state_nxt = S_CALC;
                end
                S_CALC: begin
                    state_nxt = S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        handshake = 1'b1;
                        state_nxt = (AUTO_REARM != 0) ? S_ARMED : S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Out-of-range fine codes are treated as the last bin of the period.
    always_comb begin
        start_c      = (start_lat > FINE_MAX) ? FINE_MAX : start_lat;
        stop_c       = (stop_lat > FINE_MAX) ? FINE_MAX : stop_lat;
        interval_sum = RES_W'(coarse) * BINS_RES + RES_W'(start_c) - RES_W'(stop_c);
    end

    always_ff @(posedge clk1_out or negedge rst_and_lock) begin
        if (!rst_and_lock) begin
            state      <= S_IDLE;
            coarse     <= '0;
            start_lat  <= '0;
            stop_lat   <= '0;
            to_flag    <= 1'b0;
            interval_r <= '0;
            timeout_r  <= 1'b0;
            err_r      <= 1'b0;
            cnt_r      <= '0;
        end else begin
            state <= state_nxt;
            if (handshake) cnt_r <= cnt_r + 16'd1;
            case (state)
                S_ARMED: begin
                    if (start_vld) begin
                        start_lat <= start_fine;
                        coarse    <= '0;
                        to_flag   <= 1'b0;
                        if (stop_vld) stop_lat <= stop_fine;
                    end
                end
                S_RUN: begin
                    // coarse_inc is the cycle count as seen by a stop arriving now.
                    coarse <= coarse_inc;
                    if (stop_vld) stop_lat <= stop_fine;
                    else if (coarse_inc == TIMEOUT_VAL) to_flag <= 1'b1;
                end
                S_CALC: begin
                    if (to_flag) begin
                        interval_r <= '1;
                        timeout_r  <= 1'b1;
                        err_r      <= 1'b0;
                    end else if (coarse == '0 && start_c < stop_c) begin
                        interval_r <= '0;
                        timeout_r  <= 1'b0;
                        err_r      <= 1'b1;
                    end else begin
                        interval_r <= interval_sum;
                        timeout_r  <= 1'b0;
                        err_r      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid    = (state == S_DONE);
    assign busy         = (state != S_IDLE);
    assign res_interval = interval_r;
    assign res_timeout  = timeout_r;
    assign res_err      = err_r;
    assign meas_cnt     = cnt_r;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb/tb_tdc_meas_ctrl.sv - randomized and directed bench for tdc_meas_ctrl
// Event-timestamp reference model plus literal expectations for the key scenarios.
module tb_tdc_meas_ctrl;

    localparam int BINS = 100;
    localparam int TMO  = 1000;
    localparam int RESW = 23;

    logic        clk1_out = 1'b0;
    logic        rst_and_lock = 1'b0;
    logic        arm = 1'b0, abort = 1'b0, start_vld = 1'b0, stop_vld = 1'b0, res_ready = 1'b0;
    logic [6:0]  start_fine = '0, stop_fine = '0;
    logic        res_valid, res_timeout, res_err, busy;
    logic [22:0] res_interval;
    logic [15:0] meas_cnt;

    logic        ar_arm = 1'b0, ar_abort = 1'b0, ar_start = 1'b0, ar_stop = 1'b0, ar_ready = 1'b0;
    logic [6:0]  ar_sf = '0, ar_pf = '0;
    logic        ar_valid, ar_timeout, ar_err, ar_busy;
    logic [22:0] ar_interval;
    logic [15:0] ar_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk1_out = ~clk1_out;

    tdc_meas_ctrl #(.AUTO_REARM(0)) u_dut (
        .clk1_out(clk1_out), .rst_and_lock(rst_and_lock), .arm(arm), .abort(abort),
        .start_vld(start_vld), .start_fine(start_fine), .stop_vld(stop_vld), .stop_fine(stop_fine),
        .res_valid(res_valid), .res_ready(res_ready), .res_interval(res_interval),
        .res_timeout(res_timeout), .res_err(res_err), .busy(busy), .meas_cnt(meas_cnt)
    );

    tdc_meas_ctrl #(.AUTO_REARM(1)) u_ar (
        .clk1_out(clk1_out), .rst_and_lock(rst_and_lock), .arm(ar_arm), .abort(ar_abort),
        .start_vld(ar_start), .start_fine(ar_sf), .stop_vld(ar_stop), .stop_fine(ar_pf),
        .res_valid(ar_valid), .res_ready(ar_ready), .res_interval(ar_interval),
        .res_timeout(ar_timeout), .res_err(ar_err), .busy(ar_busy), .meas_cnt(ar_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 armed, 2 running, 3 result pending.
    int m_mode = 0, m_t0 = 0, m_done = 0, m_cnt = 0, m_int = 0, m_sf = 0, cyc = 0;
    bit m_to = 0, m_err = 0;

    function automatic int clampf(input int f);
        return (f > BINS - 1) ? BINS - 1 : f;
    endfunction

    function automatic void m_result(input int coarse, input int sf, input int pf, input bit to);
        m_to  = to;
        m_err = 0;
        if (to) m_int = (1 << RESW) - 1;
        else if (coarse == 0 && clampf(sf) < clampf(pf)) begin
            m_int = 0;
            m_err = 1;
        end else m_int = coarse * BINS + clampf(sf) - clampf(pf);
        m_mode = 3;
        m_done = cyc + 2;
    endfunction

    always @(posedge clk1_out or negedge rst_and_lock) begin
        if (!rst_and_lock) begin
            m_mode = 0;
            m_cnt  = 0;
            cyc    = 0;
        end else begin
            if (abort) m_mode = 0;
            else case (m_mode)
                0: if (arm) m_mode = 1;
                1: if (start_vld) begin
                    m_t0 = cyc;
                    m_sf = int'(start_fine);
                    if (stop_vld) m_result(0, m_sf, int'(stop_fine), 0);
                    else m_mode = 2;
                end
                2: if (stop_vld) m_result(cyc - m_t0, m_sf, int'(stop_fine), 0);
                   else if (cyc - m_t0 == TMO) m_result(0, 0, 0, 1);
                3: if (cyc >= m_done && res_ready) begin
                    m_cnt  = (m_cnt + 1) % 65536;
                    m_mode = 0;
                end
                default: m_mode = 0;
            endcase
            cyc++;
        end
    end

    always @(negedge clk1_out) begin
        if (rst_and_lock) begin
            chk("valid", 32'(res_valid), 32'(m_mode == 3 && cyc >= m_done));
            chk("busy", 32'(busy), 32'(m_mode != 0));
            chk("meas_cnt", 32'(meas_cnt), m_cnt);
            if (m_mode == 3 && cyc >= m_done) begin
                chk("interval", 32'(res_interval), m_int);
                chk("timeout", 32'(res_timeout), 32'(m_to));
                chk("err", 32'(res_err), 32'(m_err));
            end
        end
    end

    task automatic step(input logic a, input logic ab, input logic sv, input logic [6:0] sf,
                        input logic pv, input logic [6:0] pf, input logic r);
        @(negedge clk1_out);
        #1;
        arm = a; abort = ab; start_vld = sv; start_fine = sf;
        stop_vld = pv; stop_fine = pf; res_ready = r;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ar_step(input logic a, input logic sv, input logic [6:0] sf,
                           input logic pv, input logic [6:0] pf, input logic r);
        @(negedge clk1_out);
        #1;
        ar_arm = a; ar_start = sv; ar_sf = sf; ar_stop = pv; ar_pf = pf; ar_ready = r;
    endtask

    task automatic handshake(input int exp_cnt);
        step(0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("cnt_after_hs", 32'(meas_cnt), exp_cnt);
        chk("busy_after_hs", 32'(busy), 0);
    endtask

    task automatic scen1(input int exp_cnt);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7'd40, 0, 0, 0);
        idle();
        idle();
        step(0, 0, 0, 0, 1, 7'd10, 0);
        idle();
        chk("s1_valid_n1", 32'(res_valid), 0);
        idle();
        chk("s1_valid_n2", 32'(res_valid), 1);
        chk("s1_interval", 32'(res_interval), 330);
        chk("s1_timeout", 32'(res_timeout), 0);
        chk("s1_err", 32'(res_err), 0);
        handshake(exp_cnt);
    endtask

    task automatic pair(input logic [6:0] sf, input logic [6:0] pf, input int ei, input int ee, input int exp_cnt);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, sf, 1, pf, 0);
        idle();
        idle();
        chk("pair_valid", 32'(res_valid), 1);
        chk("pair_interval", 32'(res_interval), ei);
        chk("pair_err", 32'(res_err), ee);
        handshake(exp_cnt);
    endtask

    initial begin
        repeat (3) @(negedge clk1_out);
        #1;
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(meas_cnt), 0);
        chk("rst_interval", 32'(res_interval), 0);
        chk("rst_flags", 32'({res_timeout, res_err}), 0);
        @(negedge clk1_out);
        #1 rst_and_lock = 1'b1;

        scen1(1);
        pair(7'd50, 7'd20, 30, 0, 2);
        pair(7'd20, 7'd50, 0, 1, 3);

        // Timeout with no stop
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7'd5, 0, 0, 0);
        repeat (TMO) idle();
        idle();
        chk("to_valid_early", 32'(res_valid), 0);
        idle();
        chk("to_valid", 32'(res_valid), 1);
        chk("to_flag", 32'(res_timeout), 1);
        chk("to_interval", 32'(res_interval), 32'h7FFFFF);
        chk("to_err", 32'(res_err), 0);
        handshake(4);

        // Stop on the timeout cycle, then backpressure
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7'd30, 0, 0, 0);
        repeat (TMO - 1) idle();
        step(0, 0, 0, 0, 1, 7'd30, 0);
        idle();
        idle();
        chk("st_valid", 32'(res_valid), 1);
        chk("st_timeout", 32'(res_timeout), 0);
        chk("st_interval", 32'(res_interval), 100000);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 7'($urandom), 1, 7'($urandom), 0);
            chk("bp_interval", 32'(res_interval), 100000);
            chk("bp_valid", 32'(res_valid), 1);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("bp_cnt", 32'(meas_cnt), 5);

        // Abort in RUN and in DONE
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7'd10, 0, 0, 0);
        idle();
        step(0, 1, 0, 0, 0, 0, 0);
        idle();
        chk("abr_busy", 32'(busy), 0);
        chk("abr_cnt", 32'(meas_cnt), 5);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7'd10, 1, 7'd5, 0);
        idle();
        idle();
        chk("abd_valid_pre", 32'(res_valid), 1);
        step(0, 1, 0, 0, 0, 0, 1);
        idle();
        chk("abd_valid", 32'(res_valid), 0);
        chk("abd_busy", 32'(busy), 0);
        chk("abd_cnt", 32'(meas_cnt), 5);

        // Stop before arm, arm during RUN
        step(0, 0, 0, 0, 1, 7'd3, 0);
        idle();
        chk("stop_idle_busy", 32'(busy), 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7'd60, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 7'd20, 0);
        idle();
        idle();
        chk("armrun_interval", 32'(res_interval), 240);
        handshake(6);

        // Asynchronous reset mid-RUN
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7'd10, 0, 0, 0);
        idle();
        #2 rst_and_lock = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(res_valid), 0);
        chk("arst_cnt", 32'(meas_cnt), 0);
        chk("arst_interval", 32'(res_interval), 0);
        chk("arst_flags", 32'({res_timeout, res_err}), 0);
        repeat (3) idle();
        @(negedge clk1_out);
        #1 rst_and_lock = 1'b1;
        scen1(1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++)
            step(($urandom % 6) == 0, ($urandom % 60) == 0, ($urandom % 5) == 0, 7'($urandom),
                 ($urandom % 5) == 0, 7'($urandom), ($urandom % 2) == 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle();

        // Auto-rearm instance, including fine code clamping
        ar_step(1, 0, 0, 0, 0, 0);
        ar_step(0, 1, 7'd60, 1, 7'd10, 0);
        ar_step(0, 0, 0, 0, 0, 0);
        ar_step(0, 0, 0, 0, 0, 0);
        chk("ar_valid", 32'(ar_valid), 1);
        chk("ar_interval", 32'(ar_interval), 50);
        ar_step(0, 0, 0, 0, 0, 1);
        ar_step(0, 0, 0, 0, 0, 0);
        chk("ar_busy_rearm", 32'(ar_busy), 1);
        chk("ar_cnt", 32'(ar_cnt), 1);
        chk("ar_valid_low", 32'(ar_valid), 0);
        ar_step(0, 1, 7'd120, 1, 7'd0, 0);
        ar_step(0, 0, 0, 0, 0, 0);
        ar_step(0, 0, 0, 0, 0, 0);
        chk("ar_valid2", 32'(ar_valid), 1);
        chk("ar_clamp_interval", 32'(ar_interval), 99);
        chk("ar_clamp_err", 32'(ar_err), 0);
        ar_step(0, 0, 0, 0, 0, 1);
        ar_step(0, 0, 0, 0, 0, 0);
        chk("ar_cnt2", 32'(ar_cnt), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
